fetch_decode_stall_pipe: RTL
============================

Name: fetch_decode_stall_pipe

Overview:
- Consumer side of the load-use hazard handshake. It owns the PC register, the IF/ID pipeline register and the ID/EX control/rt register.
- It obeys PCWrite/IFIDWrite/blockinstr: hold PC, hold IF/ID, inject a bubble into ID/EX.
- It flushes on a taken branch resolved in EX.
- It feeds rsIFID/rtIFID/rtIDEX/MemReadIDEX back to the hazard detector, and keeps stall statistics plus a stuck-stall watchdog.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 10, width of decoded control bundle from ID.
- MEMREAD_BIT, 3, index of MemRead inside the control bundle.
- CNT_W, 16, width of the total-stall counter.
- MAX_STALL, 4, consecutive stall cycles tolerated before watchdog error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- PCWrite  in  1  1 = PC may advance.
- IFIDWrite  in  1  1 = IF/ID may load.
- blockinstr  in  1  1 = insert bubble into ID/EX.
- branch_taken  in  1  taken branch resolved in EX this cycle.
- branch_target  in  32  target PC for branch_taken.
- instr_in  in  32  instruction memory data at pc.
- ctrl_id  in  CTRL_W  decoded control for instruction in IF/ID.
- pc  out  32  current fetch PC.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc4  out  32  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- rsIFID  out  5  ifid_instr[25:21].
- rtIFID  out  5  ifid_instr[20:16].
- idex_ctrl  out  CTRL_W  ID/EX control bundle.
- rtIDEX  out  5  ID/EX rt field.
- MemReadIDEX  out  1  idex_ctrl[MEMREAD_BIT].
- idex_valid  out  1  ID/EX holds a real instruction.
- stall_count  out  CNT_W  total stall cycles, saturating.
- stall_err  out  1  sticky watchdog error.

Behaviour:
Reset
- rst low forces, immediately and asynchronously:
  - pc = RESET_PC
  - ifid_instr = 0 (NOP), ifid_pc4 = 0, ifid_valid = 0
  - idex_ctrl = 0, rtIDEX = 0, idex_valid = 0
  - stall_count = 0, consecutive-stall counter = 0, stall_err = 0
- Reset mid-stall or mid-flush discards all state.

Register updates (all on the rising clock edge, rst high). Priority per cycle: flush > stall > advance.
- Flush (branch_taken = 1, overrides PCWrite, IFIDWrite and blockinstr):
  - pc <= branch_target
  - ifid_instr <= 0, ifid_valid <= 0
  - idex_ctrl <= 0, rtIDEX <= 0, idex_valid <= 0
  - Consecutive-stall counter cleared; stall_count not incremented.
- PC, no flush:
  - PCWrite = 1: pc <= pc + 4, wrapping modulo 2^32.
  - PCWrite = 0: pc held.
- IF/ID, no flush:
  - IFIDWrite = 1: ifid_instr <= instr_in, ifid_pc4 <= pc + 4, ifid_valid <= 1.
  - IFIDWrite = 0: all IF/ID fields held.
- ID/EX, no flush:
  - blockinstr = 1: idex_ctrl <= 0, rtIDEX <= 0, idex_valid <= 0.
  - Otherwise: idex_ctrl <= ctrl_id, rtIDEX <= rtIFID, idex_valid <= ifid_valid.
  - A bubble has MemReadIDEX = 0 and so cannot re-trigger a stall.
- The three write enables act independently; an inconsistent combination (e.g. PCWrite = 0, IFIDWrite = 1) is honoured literally.

Timing
- rsIFID, rtIFID and MemReadIDEX are combinational from registers.
- Load-use stall therefore lasts exactly one cycle with the standard hazard detector.

Stall statistics (a stall cycle = blockinstr = 1 and branch_taken = 0)
- Each stall cycle increments stall_count, saturating at all-ones.
- Consecutive-stall counter increments on each stall cycle and clears on any non-stall cycle.
- When the consecutive count reaches MAX_STALL + 1, stall_err is set and stays set until reset.
- The consecutive counter saturates at MAX_STALL + 1.

Test Plan:
1. Reset release with PCWrite = IFIDWrite = 1, blockinstr = 0, instr_in = 32'h8C220000 -> pc sequence 0, 4, 8; ifid_valid = 1 after first edge; ifid_pc4 = 4; rsIFID = 1, rtIFID = 2.
2. Load-use: lw $2 in ID/EX (ctrl_id MemRead bit set), then stall cycle with PCWrite = IFIDWrite = 0, blockinstr = 1 -> pc and IF/ID held one cycle; idex_ctrl = 0, idex_valid = 0, MemReadIDEX = 0; stall_count = 1.
3. branch_taken = 1, branch_target = 32'h0000_0100, coincident with blockinstr = 1 -> next pc = 0x100; ifid_valid = 0 and idex_valid = 0; stall_count unchanged.
4. blockinstr held high 5 cycles with MAX_STALL = 4 -> stall_err rises after 5th stall edge and stays 1 after blockinstr drops; stall_count = 5.
5. stall_count preloaded near max via 2^CNT_W stalls, or CNT_W = 3 with 9 stalls -> stall_count saturates at 7, no wrap.
6. rst asserted low mid-stall, asynchronously between edges -> all outputs reach reset values before next edge; pc = RESET_PC; stall_err = 0.

Source files
------------

// File: rtl/fetch_decode_stall_pipe.sv
// Fetch/decode pipeline registers that react to the load-use hazard handshake:
// PC, IF/ID and ID/EX control registers, plus stall statistics and a stuck-stall watchdog.
module fetch_decode_stall_pipe #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned CTRL_W      = 10,
    parameter int unsigned MEMREAD_BIT = 3,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MAX_STALL   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWrite,
    input  logic              IFIDWrite,
    input  logic              blockinstr,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       instr_in,
    input  logic [CTRL_W-1:0] ctrl_id,
    output logic [31:0]       pc,
    output logic [31:0]       ifid_instr,
    output logic [31:0]       ifid_pc4,
    output logic              ifid_valid,
    output logic [4:0]        rsIFID,
    output logic [4:0]        rtIFID,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [4:0]        rtIDEX,
    output logic              MemReadIDEX,
    output logic              idex_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic              stall_err
);

    localparam int unsigned         CONS_W   = $clog2(MAX_STALL + 2);
    localparam logic [CONS_W-1:0]   CONS_MAX = CONS_W'(MAX_STALL + 1);

    logic [CONS_W-1:0] cons_cnt;
    logic [31:0]       pc_plus4;
    logic              stall_cycle;

    assign pc_plus4    = pc + 32'd4;
    assign stall_cycle = blockinstr & ~branch_taken;

    assign rsIFID      = ifid_instr[25:21];
    assign rtIFID      = ifid_instr[20:16];
    assign MemReadIDEX = idex_ctrl[MEMREAD_BIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            ifid_instr  <= '0;
            ifid_pc4    <= '0;
            ifid_valid  <= 1'b0;
            idex_ctrl   <= '0;
            rtIDEX      <= '0;
            idex_valid  <= 1'b0;
            stall_count <= '0;
            cons_cnt    <= '0;
            stall_err   <= 1'b0;
        end else if (branch_taken) begin
            // Flush wins over every enable; ifid_pc4 is left as-is since ifid_valid marks it dead.
            pc         <= branch_target;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
            idex_ctrl  <= '0;
            rtIDEX     <= '0;
            idex_valid <= 1'b0;
            cons_cnt   <= '0;
        end else begin
            if (PCWrite) begin
                pc <= pc_plus4;
            end
            if (IFIDWrite) begin
                ifid_instr <= instr_in;
                ifid_pc4   <= pc_plus4;
                ifid_valid <= 1'b1;
            end
            if (blockinstr) begin
                idex_ctrl  <= '0;
                rtIDEX     <= '0;
                idex_valid <= 1'b0;
            end else begin
                idex_ctrl  <= ctrl_id;
                rtIDEX     <= rtIFID;
                idex_valid <= ifid_valid;
            end
            if (stall_cycle) begin
                if (stall_count != '1) begin
                    stall_count <= stall_count + 1'b1;
                end
                if (cons_cnt != CONS_MAX) begin
                    cons_cnt <= cons_cnt + 1'b1;
                end
                // The edge that brings the run length to MAX_STALL+1 raises the error.
                if (cons_cnt >= CONS_MAX - 1'b1) begin
                    stall_err <= 1'b1;
                end
            end else begin
                cons_cnt <= '0;
            end
        end
    end

endmodule
